tile_draw_arbiter: RTL and testbench
====================================

# tile_draw_arbiter

Shares the single VGA adapter plot port (160x120, 6-bit colour) among several game-logic requesters, such as the player sprite, the boxes and the background-clean path. Each requester asks for one 16x16 solid-colour tile at a grid cell. The block arbitrates round-robin, latches the winner's parameters and streams 256 pixels to the adapter. It sits between the game controllers and `vga_adapter`, replacing the per-controller clean/plot counters.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters.
- `COLS`, default 10: valid tile columns 0..COLS-1.
- `ROWS`, default 7: valid tile rows 0..ROWS-1.

Ports (clock and reset first):
- `CLOCK_50`  in  1: the single clock.
- `resetn`  in  1: reset, asynchronous, active-low.
- `req`  in  NUM_REQ: level request, one bit per requester.
- `tile_col`  in  4*NUM_REQ: column for requester i, in bits [4i+3:4i].
- `tile_row`  in  3*NUM_REQ: row for requester i, in bits [3i+2:3i].
- `tile_colour`  in  6*NUM_REQ: fill colour for requester i, in bits [6i+5:6i].
- `grant`  out  NUM_REQ: one-hot, 1-cycle pulse; marks the cycle the parameters were latched.
- `done`  out  NUM_REQ: one-hot, 1-cycle pulse when the granted tile has finished.
- `err`  out  1: pulses together with `done` when the tile was out of range.
- `busy`  out  1: high in every state except IDLE.
- `x`  out  8: pixel x, to the adapter.
- `y`  out  7: pixel y, to the adapter.
- `colour`  out  6: pixel colour, to the adapter.
- `plot`  out  1: adapter write enable.

## Operation
- **Reset values:** all outputs are 0. State is IDLE. The round-robin pointer is 0, so requester 0 has highest priority.
- **States:** IDLE, DRAW, DONE. All outputs are registered.
- **IDLE:**
  - With no `req` bit set, the block stays in IDLE.
  - Otherwise it selects the first set `req` bit searching upward and wrapping, starting at pointer index.
  - On that edge it pulses `grant[i]` and latches col, row and colour for requester i. It also clears the pixel counter `cnt` (8 bits).
  - If the tile is in range (col < COLS and row < ROWS), it moves to DRAW. On the same edge it drives pixel 0 with `plot`=1.
  - If the tile is out of range, it moves to DONE with `plot`=0 and marks the request as an error.
- **DRAW:**
  - Each cycle outputs x = col*16 + cnt[7:4] and y = row*16 + cnt[3:0]. The order is column-major: y is the fast index.
  - `colour` is the latched colour and `plot` is 1; `cnt` increments.
  - After the pixel with cnt=255 has been presented, the next edge sets `plot`=0 and enters DONE.
- **DONE:**
  - Pulses `done[i]` for one cycle, plus `err` if the request was flagged.
  - Sets the pointer to (i+1) mod NUM_REQ, then returns to IDLE.
- **Width rules:**
  - col*16 is computed 8 bits wide and row*16 is computed 7 bits wide.
  - In-range limits guarantee x ≤ 159 and y ≤ 111. No wrap is possible on valid tiles.
- **Request changes during a draw:**
  - Inputs that change after grant are ignored, because the parameters are latched.
  - A `req` that falls mid-draw does not abort the draw; `done` is still pulsed.
- **Re-requests and simultaneous requests:**
  - A `req` still high when the block re-enters IDLE counts as a new request.
  - Because the pointer has advanced, other waiting requesters win first.
  - Simultaneous requests are resolved purely by pointer order. No request is lost, and each waits at most NUM_REQ-1 tiles.

## Timing
- **Valid request:**
  - Grant edge = cycle G. In cycle G, `grant` and pixel 0 are both visible.
  - Pixels 0..255 occupy cycles G..G+255.
  - `done` is high in cycle G+256, and IDLE is reached in G+257.
  - The earliest next grant is at G+258, so throughput is 258 cycles per tile.
- **Out-of-range request:** `grant` in cycle G, `done` and `err` in G+1, IDLE in G+2, with no `plot`.
- **Latency:** request seen in IDLE to `grant` takes 1 edge.
- **Reset mid-operation:** the asynchronous `resetn` drops `plot`, `grant`, `done` and `busy` immediately, with no clock edge needed. The partial tile is abandoned and no `done` is pulsed.

## Structure
- **Shared package `sokoban_pkg`:**
  - TILE_PX = 16, GRID_COLS = 10, GRID_ROWS = 7.
  - Colour constants WHITE = 6'b111111 and BLACK = 6'b000000.
  - The state enum for IDLE, DRAW and DONE.
- **Sub-module `rr_picker`:** combinational; takes `req` and the pointer and returns a one-hot winner plus its index. The FSM and the pixel counter stay in the top module.

## Test plan
- **Single draw:** `req[0]`, col 3, row 2, colour WHITE. First plot at (48,32) in the grant cycle; last plot at (63,47), 255 cycles later; `done[0]` 1 cycle after that; exactly 256 plots.
- **Simultaneous requests:** `req` = 4'b1010 held from reset. Grants go to 1, then 3, then 1, then 3; each `done` matches its grant.
- **Out of range:** `req[2]` with col 10, row 0. `grant[2]`, then `done[2]` with `err` the next cycle; zero plots.
- **Ignored mid-draw changes:** change `tile_col`/`tile_colour` and drop `req` at pixel 100. Coordinates and colour stay unchanged through pixel 255, and `done` is still pulsed.
- **Reset mid-draw:** assert `resetn`=0 at pixel 50. `plot` and `busy` go to 0 within the same cycle; after release, requester 0 wins first.
- **Corner tile:** col 9, row 6. The last pixel is (159,111) and no coordinate overflows.

Source files
------------

// File: rtl/sokoban_pkg.sv
// Shared constants and types for the sokoban tile renderer: grid geometry,
// palette entries and the tile draw FSM states.
package sokoban_pkg;

  localparam int unsigned TILE_PX   = 16;
  localparam int unsigned GRID_COLS = 10;
  localparam int unsigned GRID_ROWS = 7;

  localparam logic [5:0] WHITE = 6'b111111;
  localparam logic [5:0] BLACK = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } draw_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: first set request at or above the pointer,
// wrapping; returns the one-hot winner, its index and a valid flag.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_onehot_c,
  output logic [IDX_W-1:0]   win_idx_c,
  output logic               win_valid_c
);

  always_comb begin
    int unsigned j;
    win_onehot_c = '0;
    win_idx_c    = '0;
    win_valid_c  = 1'b0;
    j            = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr_i) + k) % NUM_REQ;
      if (!win_valid_c && req_i[IDX_W'(j)]) begin
        win_valid_c                = 1'b1;
        win_onehot_c[IDX_W'(j)]    = 1'b1;
        win_idx_c                  = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/tile_draw_arbiter.sv
// Shares the VGA plot port among tile requesters: round-robin grant, latch
// the winner's tile and stream its 256 pixels column-major.
module tile_draw_arbiter
  import sokoban_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COLS    = GRID_COLS,
  parameter int unsigned ROWS    = GRID_ROWS
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] tile_col,
  input  logic [3*NUM_REQ-1:0] tile_row,
  input  logic [6*NUM_REQ-1:0] tile_colour,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic                 busy,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [5:0]           colour,
  output logic                 plot
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 8;

  draw_state_e          state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           col_q, col_d;
  logic [2:0]           row_q, row_d;
  logic [5:0]           tcol_q, tcol_d;
  logic                 flag_q, flag_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [7:0]           x_q, x_d;
  logic [6:0]           y_q, y_d;
  logic [5:0]           pcol_q, pcol_d;
  logic                 plot_q, plot_d;

  logic [NUM_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic [3:0]           col_sel;
  logic [2:0]           row_sel;
  logic [5:0]           tcol_sel;
  logic                 in_range_c;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .win_onehot_c (win_onehot),
    .win_idx_c    (win_idx),
    .win_valid_c  (win_valid)
  );

  function automatic logic [7:0] pix_x(input logic [3:0] c, input logic [CNT_W-1:0] n);
    return 8'(32'(c) * TILE_PX) + 8'(n[7:4]);
  endfunction

  function automatic logic [6:0] pix_y(input logic [2:0] r, input logic [CNT_W-1:0] n);
    return 7'(32'(r) * TILE_PX) + 7'(n[3:0]);
  endfunction

  // Mux out the winning requester's tile fields.
  always_comb begin
    col_sel  = '0;
    row_sel  = '0;
    tcol_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        col_sel  = tile_col[4*i +: 4];
        row_sel  = tile_row[3*i +: 3];
        tcol_sel = tile_colour[6*i +: 6];
      end
    end
  end

  assign in_range_c = (32'(col_sel) < COLS) && (32'(row_sel) < ROWS);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      tcol_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      pcol_q  <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tcol_q  <= tcol_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pcol_q  <= pcol_d;
      plot_q  <= plot_d;
    end
  end

  // cnt_q is the index of the pixel currently on the outputs while drawing.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    tcol_d  = tcol_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    pcol_d  = pcol_q;
    plot_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          grant_d = win_onehot;
          idx_d   = win_idx;
          col_d   = col_sel;
          row_d   = row_sel;
          tcol_d  = tcol_sel;
          cnt_d   = '0;
          if (in_range_c) begin
            state_d = ST_DRAW;
            flag_d  = 1'b0;
            x_d     = pix_x(col_sel, '0);
            y_d     = pix_y(row_sel, '0);
            pcol_d  = tcol_sel;
            plot_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            flag_d  = 1'b1;
          end
        end
      end
      ST_DRAW: begin
        if (cnt_q == '1) begin
          state_d = ST_DONE;
          done_d  = NUM_REQ'(1) << idx_q;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          x_d    = pix_x(col_q, cnt_q + CNT_W'(1));
          y_d    = pix_y(row_q, cnt_q + CNT_W'(1));
          pcol_d = tcol_q;
          plot_d = 1'b1;
        end
      end
      ST_DONE: begin
        // Error tiles arrive here without done set yet; pulse it first.
        if (done_q == '0) begin
          done_d = NUM_REQ'(1) << idx_q;
          err_d  = flag_q;
        end else begin
          state_d = ST_IDLE;
          ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = pcol_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// Directed bench for tile_draw_arbiter: single, simultaneous, out-of-range,
// mid-draw input changes, reset mid-draw and corner tile.
module tb_tile_draw_arbiter;
  import sokoban_pkg::*;

  logic        CLOCK_50;
  logic        resetn;
  logic [3:0]  req;
  logic [15:0] tile_col;
  logic [11:0] tile_row;
  logic [23:0] tile_colour;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [5:0]  colour;
  logic        plot;

  int n_checks = 0;
  int n_pass   = 0;

  int         g_t, d_t, first_t, last_t, plots, coord_bad, colour_bad;
  logic [3:0] g_val, d_val;
  logic       err_seen, busy_after;
  logic [7:0] fx, lx;
  logic [6:0] fy, ly;

  tile_draw_arbiter dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .req         (req),
    .tile_col    (tile_col),
    .tile_row    (tile_row),
    .tile_colour (tile_colour),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_tile(input int i, input logic [3:0] c, input logic [2:0] r,
                          input logic [5:0] col);
    tile_col[4*i +: 4]    = c;
    tile_row[3*i +: 3]    = r;
    tile_colour[6*i +: 6] = col;
  endtask

  // Watch one tile from request to done; mutates inputs after pixel mut_pix.
  task automatic observe(input int budget, input bit clr_on_grant, input int mut_pix,
                         input logic [3:0] ec, input logic [2:0] er, input logic [5:0] ecol);
    g_t = -1; d_t = -1; first_t = -1; last_t = -1; plots = 0;
    coord_bad = 0; colour_bad = 0; g_val = '0; d_val = '0; err_seen = 1'b0;
    fx = '0; fy = '0; lx = '0; ly = '0;
    for (int t = 0; t < budget; t++) begin
      @(negedge CLOCK_50);
      if (grant != 0 && g_t < 0) begin
        g_t = t;
        g_val = grant;
        if (clr_on_grant) req = req & ~grant;
      end
      if (plot) begin
        if (int'(x) != int'(ec) * 16 + plots / 16 || int'(y) != int'(er) * 16 + plots % 16)
          coord_bad++;
        if (colour != ecol) colour_bad++;
        if (plots == 0) begin fx = x; fy = y; first_t = t; end
        lx = x; ly = y; last_t = t;
        plots++;
        if (plots == mut_pix + 1) begin
          tile_col    = ~tile_col;
          tile_row    = ~tile_row;
          tile_colour = ~tile_colour;
          req         = '0;
        end
      end
      if (done != 0) begin
        d_t = t; d_val = done; err_seen = err;
        break;
      end
    end
    @(negedge CLOCK_50);
    busy_after = busy;
  endtask

  task automatic check_valid_tile(input string tag, input logic [3:0] eg,
                                  input logic [7:0] efx, input logic [6:0] efy,
                                  input logic [7:0] elx, input logic [6:0] ely);
    check({tag, "_grant"}, 32'(g_val), 32'(eg));
    check({tag, "_first_xy"}, {16'(fx), 16'(fy)}, {16'(efx), 16'(efy)});
    check({tag, "_first_t"}, 32'(first_t - g_t), 32'd0);
    check({tag, "_last_xy"}, {16'(lx), 16'(ly)}, {16'(elx), 16'(ely)});
    check({tag, "_last_t"}, 32'(last_t - g_t), 32'd255);
    check({tag, "_plots"}, 32'(plots), 32'd256);
    check({tag, "_coord"}, 32'(coord_bad), 32'd0);
    check({tag, "_colour"}, 32'(colour_bad), 32'd0);
    check({tag, "_done"}, 32'(d_val), 32'(eg));
    check({tag, "_done_t"}, 32'(d_t - g_t), 32'd256);
    check({tag, "_err"}, 32'(err_seen), 32'd0);
    check({tag, "_idle"}, 32'(busy_after), 32'd0);
  endtask

  initial begin
    logic [3:0] sim_g [4];
    logic [3:0] sim_c [4];
    logic [2:0] sim_r [4];
    logic [5:0] sim_k [4];
    int         gw;

    resetn = 1'b0; req = '0; tile_col = '0; tile_row = '0; tile_colour = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_outputs", {grant, done, err, busy, plot, 2'b00}, 32'd0);
    check("rst_pixel", {x, y, colour}, 32'd0);
    resetn = 1'b1;
    @(negedge CLOCK_50);

    // Single draw: requester 0, col 3, row 2, white
    set_tile(0, 4'd3, 3'd2, WHITE);
    req = 4'b0001;
    observe(400, 1'b1, -1, 4'd3, 3'd2, WHITE);
    check_valid_tile("single", 4'b0001, 8'd48, 7'd32, 8'd63, 7'd47);

    // Out of range: requester 2, col 10
    set_tile(2, 4'd10, 3'd0, WHITE);
    req = 4'b0100;
    observe(20, 1'b1, -1, 4'd10, 3'd0, WHITE);
    check("oor_grant", 32'(g_val), 32'b0100);
    check("oor_done", 32'(d_val), 32'b0100);
    check("oor_done_t", 32'(d_t - g_t), 32'd1);
    check("oor_err", 32'(err_seen), 32'd1);
    check("oor_plots", 32'(plots), 32'd0);
    check("oor_idle", 32'(busy_after), 32'd0);

    // Corner tile: requester 3, col 9, row 6
    set_tile(3, 4'd9, 3'd6, 6'h2A);
    req = 4'b1000;
    observe(400, 1'b1, -1, 4'd9, 3'd6, 6'h2A);
    check_valid_tile("corner", 4'b1000, 8'd144, 7'd96, 8'd159, 7'd111);

    // Ignored mid-draw changes: requester 1, col 4, row 5
    set_tile(1, 4'd4, 3'd5, 6'h15);
    req = 4'b0010;
    observe(400, 1'b0, 100, 4'd4, 3'd5, 6'h15);
    check_valid_tile("middraw", 4'b0010, 8'd64, 7'd80, 8'd79, 7'd95);

    // Simultaneous requests held from reset
    tile_col = '0; tile_row = '0; tile_colour = '0;
    set_tile(1, 4'd0, 3'd0, 6'h01);
    set_tile(3, 4'd2, 3'd1, 6'h03);
    resetn = 1'b0;
    req = 4'b1010;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    sim_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    sim_c = '{4'd0, 4'd2, 4'd0, 4'd2};
    sim_r = '{3'd0, 3'd1, 3'd0, 3'd1};
    sim_k = '{6'h01, 6'h03, 6'h01, 6'h03};
    for (int n = 0; n < 4; n++) begin
      observe(300, 1'b0, -1, sim_c[n], sim_r[n], sim_k[n]);
      if (n == 3) req = '0;
      check($sformatf("sim%0d_grant", n), 32'(g_val), 32'(sim_g[n]));
      check($sformatf("sim%0d_done", n), 32'(d_val), 32'(sim_g[n]));
      check($sformatf("sim%0d_plots", n), 32'(plots), 32'd256);
      check($sformatf("sim%0d_coord", n), 32'(coord_bad), 32'd0);
      if (n > 0) check($sformatf("sim%0d_gap", n), 32'(g_t), 32'd0);
    end
    @(negedge CLOCK_50);

    // Reset mid-draw: requester 2 at pixel 50
    set_tile(2, 4'd1, 3'd1, 6'h0C);
    req = 4'b0100;
    gw = -1;
    for (int t = 0; t < 10; t++) begin
      @(negedge CLOCK_50);
      if (grant != 0) begin gw = t; break; end
    end
    check("rstmid_grant", 32'(grant), 32'b0100);
    check("rstmid_seen", 32'(gw >= 0), 32'd1);
    repeat (50) @(negedge CLOCK_50);
    check("rstmid_px50", {16'(x), 8'(y), 7'd0, plot}, {16'd19, 8'd18, 7'd0, 1'b1});
    set_tile(0, 4'd5, 3'd3, WHITE);
    req = 4'b0101;
    #1 resetn = 1'b0;
    #1;
    check("rstmid_async", {28'd0, plot, busy, err, |done}, 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    observe(400, 1'b1, -1, 4'd5, 3'd3, WHITE);
    check_valid_tile("after_rst", 4'b0001, 8'd80, 7'd48, 8'd95, 7'd63);

    req = '0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
